// File: rtl/stream_test_pkg.sv
// Constants shared by the incrementing-stream generator and stream_checker:
// state encoding, data width and default parameter values.
package stream_test_pkg;

  localparam int STREAM_W    = 32;
  localparam int ERR_W_DEF   = 16;
  localparam int TIMEOUT_DEF = 64;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SYNC  = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;

  function automatic logic [STREAM_W-1:0] next_word(input logic [STREAM_W-1:0] w);
    return w + 1'b1;
  endfunction

endpackage

// File: rtl/stream_checker_sat_counter.sv
// sat_counter: up-counter with synchronous clear that sticks at all-ones.
// Clear has priority over increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/stream_checker.sv
// stream_checker: locks onto an incrementing 32-bit stream, counts words and
// mismatches, and captures the first mismatch. Optional gap timeout: STREAM_CHECKER_GAP_TIMEOUT_EN.
module stream_checker
  import stream_test_pkg::*;
#(
  parameter int ERR_W   = ERR_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                clear,
  input  logic [STREAM_W-1:0] stream_32,
  input  logic                num_32_rdy,
  output logic                locked,
  output logic                error,
  output logic [ERR_W-1:0]    err_count,
  output logic [STREAM_W-1:0] word_count,
  output logic [STREAM_W-1:0] first_exp,
  output logic [STREAM_W-1:0] first_got,
  output logic                timeout,
  output logic [1:0]          dbg_state
);

  // Handshake: num_32_rdy qualifies stream_32 for exactly one cycle; there is
  // no backpressure, so every qualified word in SYNC/CHECK is consumed.
  logic [1:0]          state;
  logic [STREAM_W-1:0] expected;
  logic                accept;
  logic                in_check;
  logic                mismatch;
  logic                timeout_hit;

  assign in_check  = (state == ST_CHECK);
  assign accept    = num_32_rdy && enable && !clear && (state != ST_IDLE);
  assign mismatch  = (stream_32 != expected);
  assign locked    = in_check;
  assign dbg_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else if (clear) begin
      state <= enable ? ST_SYNC : ST_IDLE;
    end else if (!enable) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  state <= ST_SYNC;
        ST_SYNC:  if (accept) state <= ST_CHECK;
        ST_CHECK: if (timeout_hit) state <= ST_SYNC;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Resync on every word so one dropped word costs exactly one error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      expected <= '0;
    end else if (accept) begin
      expected <= next_word(stream_32);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_count <= '0;
    end else if (clear) begin
      word_count <= '0;
    end else if (accept) begin
      word_count <= word_count + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      error     <= 1'b0;
      first_exp <= '0;
      first_got <= '0;
    end else if (clear) begin
      error     <= 1'b0;
      first_exp <= '0;
      first_got <= '0;
    end else if (accept && in_check && mismatch && !error) begin
      error     <= 1'b1;
      first_exp <= expected;
      first_got <= stream_32;
    end
  end

  sat_counter #(.W(ERR_W)) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (clear),
    .inc   (accept && in_check && mismatch),
    .count (err_count)
  );

`ifdef STREAM_CHECKER_GAP_TIMEOUT_EN
  localparam int GAP_W = $clog2(TIMEOUT + 1);

  logic [GAP_W-1:0] gap_cnt;
  logic             timeout_q;
  logic             gap_clr;

  // The counter value is the number of word-less CHECK cycles already seen,
  // so the hit fires on the TIMEOUT-th such cycle.
  assign timeout_hit = enable && !clear && in_check && !accept &&
                       (gap_cnt == GAP_W'(TIMEOUT - 1));
  assign gap_clr     = clear || accept || !in_check || !enable || timeout_hit;

  sat_counter #(.W(GAP_W)) u_gap_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (gap_clr),
    .inc   (1'b1),
    .count (gap_cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeout_q <= 1'b0;
    end else if (clear) begin
      timeout_q <= 1'b0;
    end else if (timeout_hit) begin
      timeout_q <= 1'b1;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout_hit = 1'b0;
  // Always 0; referencing TIMEOUT keeps the parameter live in this build.
  assign timeout     = (TIMEOUT < 0);
`endif

endmodule

// File: tb/tb_stream_checker.sv
// Directed self-checking bench for stream_checker; the timeout scenario adapts
// to whether STREAM_CHECKER_GAP_TIMEOUT_EN is defined.
module tb_stream_checker;

  localparam int ERR_W = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        clear;
  logic [31:0] stream_32;
  logic        num_32_rdy;
  logic        locked;
  logic        error;
  logic [15:0] err_count;
  logic [31:0] word_count;
  logic [31:0] first_exp;
  logic [31:0] first_got;
  logic        timeout;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  stream_checker #(.ERR_W(ERR_W), .TIMEOUT(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .clear      (clear),
    .stream_32  (stream_32),
    .num_32_rdy (num_32_rdy),
    .locked     (locked),
    .error      (error),
    .err_count  (err_count),
    .word_count (word_count),
    .first_exp  (first_exp),
    .first_got  (first_got),
    .timeout    (timeout),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks: inputs change on the falling edge, outputs are sampled there too
  task automatic put(input logic [31:0] w);
    stream_32  = w;
    num_32_rdy = 1'b1;
    @(negedge clk);
    num_32_rdy = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(2);
    n_checks++; if (dbg_state !== 2'd0) begin n_errors++; $display("FAIL reset_state: got %0d exp 0", dbg_state); end
    n_checks++; if (locked !== 1'b0 || error !== 1'b0 || timeout !== 1'b0) begin n_errors++; $display("FAIL reset_flags: got %b%b%b exp 000", locked, error, timeout); end
    n_checks++; if (word_count !== 32'd0 || err_count !== 16'd0) begin n_errors++; $display("FAIL reset_counts: got %0d/%0d exp 0/0", word_count, err_count); end
    n_checks++; if (first_exp !== 32'd0 || first_got !== 32'd0) begin n_errors++; $display("FAIL reset_capture: got %0h/%0h exp 0/0", first_exp, first_got); end
    rst = 1'b0;
    idle(1);
  endtask

  task automatic test_seed_count();
    enable = 1'b1;
    idle(1);
    n_checks++; if (dbg_state !== 2'd1) begin n_errors++; $display("FAIL seed_sync_state: got %0d exp 1", dbg_state); end
    n_checks++; if (locked !== 1'b0) begin n_errors++; $display("FAIL seed_unlocked: got %b exp 0", locked); end
    put(32'd5);
    n_checks++; if (locked !== 1'b1) begin n_errors++; $display("FAIL seed_locked: got %b exp 1", locked); end
    n_checks++; if (word_count !== 32'd1) begin n_errors++; $display("FAIL seed_wc1: got %0d exp 1", word_count); end
    put(32'd6); put(32'd7); put(32'd8);
    n_checks++; if (word_count !== 32'd4) begin n_errors++; $display("FAIL seed_wc4: got %0d exp 4", word_count); end
    n_checks++; if (err_count !== 16'd0 || error !== 1'b0) begin n_errors++; $display("FAIL seed_noerr: got %0d/%b exp 0/0", err_count, error); end
  endtask

  task automatic test_drop_resync();
    pulse_clear();
    put(32'd10); put(32'd11); put(32'd13);
    n_checks++; if (err_count !== 16'd1 || error !== 1'b1) begin n_errors++; $display("FAIL drop_edge: got %0d/%b exp 1/1", err_count, error); end
    put(32'd14);
    n_checks++; if (err_count !== 16'd1) begin n_errors++; $display("FAIL drop_err1: got %0d exp 1", err_count); end
    n_checks++; if (first_exp !== 32'd12 || first_got !== 32'd13) begin n_errors++; $display("FAIL drop_capture: got %0d/%0d exp 12/13", first_exp, first_got); end
    n_checks++; if (word_count !== 32'd4) begin n_errors++; $display("FAIL drop_wc: got %0d exp 4", word_count); end
    put(32'd15); put(32'd17);
    n_checks++; if (err_count !== 16'd2) begin n_errors++; $display("FAIL drop_err2: got %0d exp 2", err_count); end
    n_checks++; if (first_exp !== 32'd12 || first_got !== 32'd13 || error !== 1'b1) begin n_errors++; $display("FAIL drop_capture_hold: got %0d/%0d/%b exp 12/13/1", first_exp, first_got, error); end
  endtask

  task automatic test_wrap();
    pulse_clear();
    put(32'hFFFF_FFFE); put(32'hFFFF_FFFF); put(32'h0000_0000);
    n_checks++; if (err_count !== 16'd0 || error !== 1'b0) begin n_errors++; $display("FAIL wrap_err: got %0d/%b exp 0/0", err_count, error); end
    n_checks++; if (word_count !== 32'd3) begin n_errors++; $display("FAIL wrap_wc: got %0d exp 3", word_count); end
  endtask

  task automatic test_clear_collision();
    put(32'd7);  // deliberate mismatch so clear has something to wipe
    n_checks++; if (error !== 1'b1) begin n_errors++; $display("FAIL coll_pre_error: got %b exp 1", error); end
    clear = 1'b1; stream_32 = 32'd99; num_32_rdy = 1'b1;
    @(negedge clk);
    clear = 1'b0; num_32_rdy = 1'b0;
    n_checks++; if (word_count !== 32'd0 || err_count !== 16'd0 || error !== 1'b0) begin n_errors++; $display("FAIL coll_stats: got %0d/%0d/%b exp 0/0/0", word_count, err_count, error); end
    n_checks++; if (first_exp !== 32'd0 || first_got !== 32'd0) begin n_errors++; $display("FAIL coll_capture: got %0h/%0h exp 0/0", first_exp, first_got); end
    n_checks++; if (dbg_state !== 2'd1) begin n_errors++; $display("FAIL coll_state: got %0d exp 1", dbg_state); end
    put(32'd200); put(32'd201);
    n_checks++; if (error !== 1'b0 || word_count !== 32'd2 || locked !== 1'b1) begin n_errors++; $display("FAIL coll_reseed: got %b/%0d/%b exp 0/2/1", error, word_count, locked); end
  endtask

  task automatic test_pause();
    pulse_clear();
    put(32'd299); put(32'd300);
    enable = 1'b0;
    idle(1);
    n_checks++; if (dbg_state !== 2'd0 || locked !== 1'b0) begin n_errors++; $display("FAIL pause_idle: got %0d/%b exp 0/0", dbg_state, locked); end
    put(32'd77);
    idle(8);
    n_checks++; if (word_count !== 32'd2) begin n_errors++; $display("FAIL pause_hold_wc: got %0d exp 2", word_count); end
    enable = 1'b1;
    idle(1);
    put(32'd500); put(32'd501);
    n_checks++; if (error !== 1'b0 || err_count !== 16'd0) begin n_errors++; $display("FAIL pause_reseed: got %b/%0d exp 0/0", error, err_count); end
    n_checks++; if (word_count !== 32'd4 || locked !== 1'b1) begin n_errors++; $display("FAIL pause_wc: got %0d/%b exp 4/1", word_count, locked); end
  endtask

  task automatic test_timeout();
    idle(60);
`ifdef STREAM_CHECKER_GAP_TIMEOUT_EN
    n_checks++; if (timeout !== 1'b0) begin n_errors++; $display("FAIL to_early: got %b exp 0", timeout); end
    idle(5);
    n_checks++; if (timeout !== 1'b1 || locked !== 1'b0 || dbg_state !== 2'd1) begin n_errors++; $display("FAIL to_set: got %b/%b/%0d exp 1/0/1", timeout, locked, dbg_state); end
    put(32'd1000); put(32'd1001);
    n_checks++; if (error !== 1'b0 || locked !== 1'b1 || word_count !== 32'd6) begin n_errors++; $display("FAIL to_reseed: got %b/%b/%0d exp 0/1/6", error, locked, word_count); end
`else
    idle(10);
    n_checks++; if (timeout !== 1'b0 || locked !== 1'b1) begin n_errors++; $display("FAIL to_disabled: got %b/%b exp 0/1", timeout, locked); end
    put(32'd502);
    n_checks++; if (error !== 1'b0 || word_count !== 32'd5) begin n_errors++; $display("FAIL to_continue: got %b/%0d exp 0/5", error, word_count); end
`endif
  endtask

  task automatic test_reset_mid();
    pulse_clear();
    put(32'd1); put(32'd2); put(32'd9);
    n_checks++; if (error !== 1'b1 || err_count !== 16'd1) begin n_errors++; $display("FAIL rst_pre: got %b/%0d exp 1/1", error, err_count); end
    stream_32 = 32'd10; num_32_rdy = 1'b1;
    #2 rst = 1'b1;
    #1;
    n_checks++; if (dbg_state !== 2'd0 || locked !== 1'b0 || error !== 1'b0 || timeout !== 1'b0) begin n_errors++; $display("FAIL rst_async_flags: got %0d/%b/%b/%b exp 0/0/0/0", dbg_state, locked, error, timeout); end
    n_checks++; if (word_count !== 32'd0 || err_count !== 16'd0 || first_exp !== 32'd0 || first_got !== 32'd0) begin n_errors++; $display("FAIL rst_async_data: got %0d/%0d/%0h/%0h exp 0/0/0/0", word_count, err_count, first_exp, first_got); end
    num_32_rdy = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    idle(1);
    put(32'd50); put(32'd51);
    n_checks++; if (error !== 1'b0 || word_count !== 32'd2 || locked !== 1'b1) begin n_errors++; $display("FAIL rst_reseed: got %b/%0d/%b exp 0/2/1", error, word_count, locked); end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; clear = 1'b0;
    stream_32 = '0; num_32_rdy = 1'b0;
    @(negedge clk);
    test_reset();
    test_seed_count();
    test_drop_resync();
    test_wrap();
    test_clear_collision();
    test_pause();
    test_timeout();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/stream_checker.md
# stream_checker

Consumer-side checker for the 32-bit incrementing test stream after its round trip through SDRAM. It samples each word qualified by `num_32_rdy` and locks onto the first word. It then verifies that every later word equals the previous word + 1 (mod 2^32), and keeps word/error statistics plus a capture of the first mismatch for the host/debug readout. It sits directly downstream of the SDRAM read path and mirrors the stream generator feeding the write path.

## Interface
Parameters:
- `ERR_W`, 16: width of the saturating error counter.
- `TIMEOUT`, 64: maximum clk cycles allowed between accepted words while in CHECK (used only with the gap-timeout feature).

Ports:
- `clk`, input, 1: single clock; all logic is on its rising edge.
- `rst`, input, 1: reset, asynchronous and active-high.
- `enable`, input, 1: checker run control.
- `clear`, input, 1: synchronous one-cycle clear of statistics and captures.
- `stream_32`, input, 32: data word under test.
- `num_32_rdy`, input, 1: `stream_32` is valid this cycle. It is a single-cycle qualifier with no backpressure.
- `locked`, output, 1: the checker has seeded its expected value and is comparing words.
- `error`, output, 1: sticky; set on the first mismatch.
- `err_count`, output, ERR_W: mismatch count, saturating.
- `word_count`, output, 32: accepted word count, wraps.
- `first_exp`, output, 32: expected value at the first mismatch.
- `first_got`, output, 32: received value at the first mismatch.
- `timeout`, output, 1: sticky; set when the inter-word gap is exceeded. Tied to 0 when the gap-timeout feature is compiled out.

## Operation
- States: IDLE, SYNC, CHECK.
  - IDLE→SYNC when `enable`=1.
  - SYNC→CHECK on the first accepted word.
  - Any state→IDLE when `enable`=0.
- An accepted word is a cycle with `num_32_rdy`=1 and the checker in SYNC or CHECK.
  - Words presented in IDLE are ignored.
- SYNC: on an accepted word, set `expected` = `stream_32`+1 and increment `word_count`.
  - The seed word itself is never counted as an error.
- CHECK: on each accepted word, increment `word_count`.
  - If `stream_32` ≠ `expected`: increment `err_count`, saturating at 2^ERR_W−1.
  - If `error` was 0 at that mismatch: load `first_exp`/`first_got` and set `error`.
  - Always resync: `expected` = `stream_32`+1. A single dropped word therefore costs exactly one error.
- Wrap-around: `expected` 0xFFFFFFFF followed by received 0x00000000 is a match. `word_count` wraps 0xFFFFFFFF→0 silently.
- `enable` deasserted: the state goes to IDLE, all statistics hold, and `locked`=0.
  - Re-enabling re-enters SYNC and re-seeds, which avoids a false error after a pause.
- `clear`: zeroes `word_count`, `err_count`, `error`, `first_exp`, `first_got`, `timeout`, and the gap counter. The state goes to SYNC if `enable`=1, otherwise IDLE.
  - `clear` and `num_32_rdy` in the same cycle: `clear` wins and the word is dropped (not counted, not seeded).
- `locked` = (state == CHECK).

## Timing
- All outputs are registered.
  - An accepted word in cycle N is reflected in `word_count`, `err_count`, `error`, and the captures at edge N+1.
  - A SYNC→CHECK transition triggered by a word in cycle N raises `locked` from N+1.
- Back-to-back `num_32_rdy` on every cycle is supported with no loss.
- `rst` asserted, asynchronous: state IDLE, `expected`=0, and every output 0.
  - Reset mid-stream discards any partial comparison.
  - First accepted word after reset release is a seed, never a compare.

## Configuration
- `STREAM_CHECKER_GAP_TIMEOUT_EN` defined:
  - A gap counter runs in CHECK and resets on each accepted word.
  - When the count reaches `TIMEOUT` cycles without a word, `timeout` is set (sticky) and the state returns to SYNC. The next word re-seeds and does not count as an error.
  - The counter is cleared and held in IDLE and SYNC.
- Macro undefined: no gap counter is built, `timeout` is constant 0, and CHECK waits indefinitely.

## Structure
- Shared package `stream_test_pkg`:
  - state encoding (IDLE=0, SYNC=1, CHECK=2, 2 bits);
  - `STREAM_W`=32;
  - default `ERR_W` and `TIMEOUT`.
- These constants are shared with the stream generator.
- One sub-module: `sat_counter` (parameterised width, increment, synchronous clear, saturation). It is used for `err_count`, and for the gap counter when the feature is enabled.

## Test plan
- Seed and count: enable, then words 5,6,7,8 on consecutive cycles → `locked`=1 from the cycle after 5, `word_count`=4, `err_count`=0, `error`=0.
- Drop and resync: words 10,11,13,14 → `err_count`=1, `first_exp`=12, `first_got`=13, `error`=1. A further 15,17 → `err_count`=2, captures unchanged.
- Wrap: words 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000 → `err_count`=0, `word_count`=3.
- Clear collision: `clear` and `num_32_rdy` (data 99) in the same cycle → all statistics 0, state SYNC. The next word 200 seeds; 201 → no error.
- Pause and reset:
  - `enable` low for 10 cycles, then high and word 500 after 300 → no error.
  - Assert `rst` mid-stream → all outputs 0 immediately, state IDLE.
- Timeout, with the macro defined and `TIMEOUT`=64: 65 idle cycles in CHECK → `timeout`=1, `locked`=0. The next word re-seeds with no error. With the macro undefined, `timeout` stays 0.
